// File: rtl/wb_commit_buffer.sv
// Writeback commit buffer: selects the MEM/WB writeback value, queues (rd, data) and drains it to the register file.
// Optional macro WB_FWD_EN builds the pending-entry forwarding lookup; otherwise fwd_* are tied to zero.

package wb_commit_buffer_pkg;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned XLEN   = 32;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;
endpackage

module wb_commit_buffer
  import wb_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             lui_in,
  input  logic             auipc_in,
  input  logic             mem_to_reg_in,
  input  logic             reg_write_in,
  input  logic [31:0]      inst_in,
  input  logic [31:0]      j_type_in,
  input  logic [31:0]      u_type_in,
  input  logic [31:0]      load_data_in,
  input  logic [31:0]      alu_result_in,
  output logic             in_ready,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  input  logic             rf_ready,
  input  logic [4:0]       fwd_rs1_addr,
  input  logic [4:0]       fwd_rs2_addr,
  output logic             fwd_rs1_hit,
  output logic             fwd_rs2_hit,
  output logic [31:0]      fwd_rs1_data,
  output logic [31:0]      fwd_rs2_data,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;

  wb_entry_t         mem [DEPTH];
  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  rd_ptr;
  logic [REG_W-1:0]  rd;
  logic [6:0]        opcode;
  logic [XLEN-1:0]   wb_data;
  logic              full;
  logic              empty;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              unused_inst;

  assign rd          = inst_in[11:7];
  assign opcode      = inst_in[6:0];
  assign unused_inst = ^inst_in[31:12];

  // Writeback value select, highest priority first
  always_comb begin
    wb_data = alu_result_in;
    if (lui_in || auipc_in) begin
      wb_data = u_type_in;
    end else if (opcode == OP_JAL || opcode == OP_JALR) begin
      wb_data = j_type_in;
    end else if (mem_to_reg_in) begin
      wb_data = load_data_in;
    end
  end

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full || rf_ready;

  assign push_req = start && reg_write_in && (rd != '0);
  assign pop      = rf_we && rf_ready;
  assign push_ok  = push_req && (!full || pop);

  // Show-ahead head; holds while the register file stalls
  assign rf_we    = !empty;
  assign rf_waddr = mem[IDX_W'(rd_ptr)].rd;
  assign rf_wdata = mem[IDX_W'(rd_ptr)].data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CNT_W'(1);
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // Entry storage is not reset; validity comes from the pointers
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[IDX_W'(wr_ptr)] <= '{rd: rd, data: wb_data};
    end
  end

`ifdef WB_FWD_EN
  logic [IDX_W-1:0] slot;

  // Walk oldest to youngest so the youngest match wins
  always_comb begin
    fwd_rs1_hit  = 1'b0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_data = '0;
    slot         = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = IDX_W'(rd_ptr + CNT_W'(k));
      if (CNT_W'(k) < count) begin
        if (fwd_rs1_addr != '0 && mem[slot].rd == fwd_rs1_addr) begin
          fwd_rs1_hit  = 1'b1;
          fwd_rs1_data = mem[slot].data;
        end
        if (fwd_rs2_addr != '0 && mem[slot].rd == fwd_rs2_addr) begin
          fwd_rs2_hit  = 1'b1;
          fwd_rs2_data = mem[slot].data;
        end
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd   = ^{fwd_rs1_addr, fwd_rs2_addr};
  assign fwd_rs1_hit  = 1'b0;
  assign fwd_rs2_hit  = 1'b0;
  assign fwd_rs1_data = 32'h0;
  assign fwd_rs2_data = 32'h0;
`endif

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Directed self-checking bench for wb_commit_buffer (DEPTH=4).
module tb_wb_commit_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start, lui_in, auipc_in, mem_to_reg_in, reg_write_in;
  logic [31:0] inst_in, j_type_in, u_type_in, load_data_in, alu_result_in;
  logic        in_ready, rf_we, rf_ready;
  logic [4:0]  rf_waddr, fwd_rs1_addr, fwd_rs2_addr;
  logic [31:0] rf_wdata, fwd_rs1_data, fwd_rs2_data;
  logic        fwd_rs1_hit, fwd_rs2_hit, overflow;
  logic [2:0]  count;
  int          checks = 0;
  int          failures = 0;

  wb_commit_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .lui_in(lui_in), .auipc_in(auipc_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .inst_in(inst_in),
    .j_type_in(j_type_in), .u_type_in(u_type_in), .load_data_in(load_data_in),
    .alu_result_in(alu_result_in), .in_ready(in_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_ready(rf_ready), .fwd_rs1_addr(fwd_rs1_addr),
    .fwd_rs2_addr(fwd_rs2_addr), .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic clear_payload();
    start = 0; lui_in = 0; auipc_in = 0; mem_to_reg_in = 0; reg_write_in = 0;
    inst_in = 32'h0; j_type_in = 32'h0; u_type_in = 32'h0; load_data_in = 32'h0; alu_result_in = 32'h0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] data);
    clear_payload();
    start = 1; reg_write_in = 1;
    inst_in = {20'h0, rd, 7'b0110011};
    alu_result_in = data;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clear_payload();
    reset = 0; rf_ready = 0; fwd_rs1_addr = 0; fwd_rs2_addr = 0;
    step(); step();
    reset = 1;
    step();
  endtask

  task automatic test_reset();
    clear_payload();
    reset = 0; rf_ready = 0; fwd_rs1_addr = 5'd7; fwd_rs2_addr = 5'd3;
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0h exp=0", rf_we); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if ({fwd_rs1_hit, fwd_rs2_hit} !== 2'b00 || fwd_rs1_data !== 32'h0 || fwd_rs2_data !== 32'h0) begin
      failures++; $display("FAIL reset_fwd got=%b/%h/%h exp=00/0/0", {fwd_rs1_hit, fwd_rs2_hit}, fwd_rs1_data, fwd_rs2_data); end
    reset = 1; fwd_rs1_addr = 0; fwd_rs2_addr = 0;
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_release_we got=%0h exp=0", rf_we); end
  endtask

  task automatic test_lui();
    clear_payload();
    start = 1; reg_write_in = 1; lui_in = 1; inst_in = {20'h0, 5'd5, 7'b0110111};
    u_type_in = 32'h12345000; alu_result_in = 32'hBAD0BAD0; rf_ready = 1;
    step();
    clear_payload();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h12345000) begin
      failures++; $display("FAIL lui_write got=%0h/%0d/%h exp=1/5/12345000", rf_we, rf_waddr, rf_wdata); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL lui_count1 got=%0d exp=1", count); end
    step();
    checks++; if (count !== 3'd0 || rf_we !== 1'b0) begin
      failures++; $display("FAIL lui_drained got=%0d/%0h exp=0/0", count, rf_we); end
  endtask

  task automatic test_data_select();
    logic [6:0]  ops  [5];
    logic        m2r  [5];
    logic        auip [5];
    logic [31:0] exp  [5];
    ops  = '{7'b1101111, 7'b1100111, 7'b0000011, 7'b0110011, 7'b0010111};
    m2r  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    auip = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp  = '{32'h104, 32'h104, 32'hDEADBEEF, 32'h0000A1A1, 32'h00400000};
    rf_ready = 1;
    for (int i = 0; i < 5; i++) begin
      clear_payload();
      start = 1; reg_write_in = 1; mem_to_reg_in = m2r[i]; auipc_in = auip[i];
      inst_in = {20'h0, 5'd1, ops[i]};
      j_type_in = 32'h104; u_type_in = 32'h00400000; load_data_in = 32'hDEADBEEF; alu_result_in = 32'h0000A1A1;
      step();
      clear_payload();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== exp[i]) begin
        failures++; $display("FAIL select_%0d got=%0h/%0d/%h exp=1/1/%h", i, rf_we, rf_waddr, rf_wdata, exp[i]); end
      step();
    end
    // x0 destination is discarded
    clear_payload();
    start = 1; reg_write_in = 1; mem_to_reg_in = 1; inst_in = {20'h0, 5'd0, 7'b1101111}; j_type_in = 32'h104;
    step();
    clear_payload();
    checks++; if (rf_we !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL x0_discard got=%0h/%0d/%0h exp=0/0/0", rf_we, count, overflow); end
    // start low ignores the payload
    set_alu(5'd9, 32'h99); start = 0;
    step();
    clear_payload();
    checks++; if (rf_we !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL start_low got=%0h/%0d exp=0/0", rf_we, count); end
  endtask

  task automatic test_overflow();
    rf_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      set_alu(5'(i), 32'(100 + i));
      step();
    end
    clear_payload();
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ovf_in_ready got=%0h exp=0", in_ready); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0h exp=1", overflow); end
    rf_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== 32'(100 + i)) begin
        failures++; $display("FAIL ovf_drain_%0d got=%0h/%0d/%0d exp=1/%0d/%0d", i, rf_we, rf_waddr, rf_wdata, i, 100 + i); end
      step();
    end
    checks++; if (rf_we !== 1'b0 || count !== 3'd0 || overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_after got=%0h/%0d/%0h exp=0/0/1", rf_we, count, overflow); end
    do_reset();
  endtask

  task automatic test_full_push_pop();
    logic [4:0] order [4];
    order = '{5'd2, 5'd3, 5'd4, 5'd6};
    rf_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      set_alu(5'(i), 32'(200 + i));
      step();
    end
    rf_ready = 1;
    set_alu(5'd6, 32'd206);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fpp_in_ready got=%0h exp=1", in_ready); end
    step();
    clear_payload();
    checks++; if (count !== 3'd4 || overflow !== 1'b0) begin
      failures++; $display("FAIL fpp_count got=%0d/%0h exp=4/0", count, overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rf_we !== 1'b1 || rf_waddr !== order[i]) begin
        failures++; $display("FAIL fpp_order_%0d got=%0h/%0d exp=1/%0d", i, rf_we, rf_waddr, order[i]); end
      step();
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL fpp_empty got=%0d exp=0", count); end
  endtask

  task automatic test_forward();
    logic        exp_hit;
    logic [31:0] exp_b, exp_c;
`ifdef WB_FWD_EN
    exp_hit = 1'b1; exp_b = 32'hBBBB0000; exp_c = 32'hCCCC0000;
`else
    exp_hit = 1'b0; exp_b = 32'h0; exp_c = 32'h0;
`endif
    rf_ready = 0;
    set_alu(5'd7, 32'hAAAA0000); step();
    set_alu(5'd7, 32'hBBBB0000); step();
    set_alu(5'd3, 32'hCCCC0000); step();
    // Current-cycle payload must not be searched
    set_alu(5'd9, 32'h99999999); start = 0;
    fwd_rs1_addr = 5'd7; fwd_rs2_addr = 5'd0;
    #1;
    checks++; if (fwd_rs1_hit !== exp_hit || fwd_rs1_data !== exp_b) begin
      failures++; $display("FAIL fwd_youngest got=%0h/%h exp=%0h/%h", fwd_rs1_hit, fwd_rs1_data, exp_hit, exp_b); end
    checks++; if (fwd_rs2_hit !== 1'b0) begin failures++; $display("FAIL fwd_x0 got=%0h exp=0", fwd_rs2_hit); end
    fwd_rs1_addr = 5'd9; fwd_rs2_addr = 5'd3; start = 1;
    #1;
    checks++; if (fwd_rs1_hit !== 1'b0) begin failures++; $display("FAIL fwd_miss got=%0h exp=0", fwd_rs1_hit); end
    checks++; if (fwd_rs2_hit !== exp_hit || fwd_rs2_data !== exp_c) begin
      failures++; $display("FAIL fwd_rs2 got=%0h/%h exp=%0h/%h", fwd_rs2_hit, fwd_rs2_data, exp_hit, exp_c); end
    clear_payload(); fwd_rs1_addr = 0; fwd_rs2_addr = 0;
    rf_ready = 1;
    step(); step(); step();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL fwd_drain got=%0d exp=0", count); end
  endtask

  task automatic test_async_reset();
    rf_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      set_alu(5'(10 + i), 32'(300 + i));
      step();
    end
    clear_payload();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL arst_pre got=%0d exp=3", count); end
    #2 reset = 0;
    #1;
    checks++; if (rf_we !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL arst_async got=%0h/%0d exp=0/0", rf_we, count); end
    rf_ready = 1;
    @(posedge clk); #2;
    reset = 1;
    step();
    checks++; if (rf_we !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL arst_stale got=%0h/%0d exp=0/0", rf_we, count); end
  endtask

  task automatic test_back_to_back();
    rf_ready = 1;
    for (int i = 0; i < 4; i++) begin
      set_alu(5'(20 + i), 32'(400 + i));
      step();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(20 + i) || count !== 3'd1) begin
        failures++; $display("FAIL b2b_%0d got=%0h/%0d/%0d exp=1/%0d/1", i, rf_we, rf_waddr, count, 20 + i); end
    end
    clear_payload();
    step();
    checks++; if (rf_we !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL b2b_end got=%0h/%0d exp=0/0", rf_we, count); end
  endtask

  initial begin
    test_reset();
    test_lui();
    test_data_select();
    test_overflow();
    test_full_push_pop();
    test_forward();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
